lfsr_rr_ctrl: RTL and testbench

- Controller that shares one 4-bit Fibonacci LFSR (polynomial X4+X3+1) between two requesters.
- Arbitrates requests round-robin, then advances the LFSR a fixed number of steps per request to decorrelate consecutive words.
- Delivers one word per grant, with a one-cycle valid/grant pulse.
- Also handles seed loading and all-zero lock-up protection.
- Sits between the random-stimulus consumers (test-pattern blocks, scramblers) and the shared generator.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr4_ld.sv | 27 ++
 rtl/lfsr_rr_ctrl.sv | 117 +++++++++++
 tb/tb_lfsr_rr_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the round-robin LFSR controller.
// The step function lives here so the LFSR register and any future user agree on it.
package lfsr_pkg;

  localparam int LFSR_W = 4;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 4'b0001;
  // x^4 + x^3 + 1: feedback is q[3] ^ q[0]
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 4'b1001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {^(q & LFSR_TAP_MASK), q[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr4_ld.sv
// Loadable, enabled 4-bit Fibonacci LFSR register.
// A load wins over a shift; next is the combinational successor of q.
module lfsr4_ld
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ld,
  input  logic [LFSR_W-1:0] ld_val,
  output logic [LFSR_W-1:0] q,
  output logic [LFSR_W-1:0] next
);

  assign next = lfsr_step(q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED_DEF;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      q <= next;
    end
  end

endmodule

// File: rtl/lfsr_rr_ctrl.sv
// Round-robin controller sharing one LFSR between two requesters.
// Valid/grant handshake: a requester holds its level request until its one-cycle grant pulse; data_o is fresh only while valid_o is high.
module lfsr_rr_ctrl
  import lfsr_pkg::*;
#(
  parameter int STEPS = 4,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_we_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              req0_i,
  input  logic              req1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              valid_o,
  output logic [LFSR_W-1:0] data_o,
  output logic              busy_o,
  output logic              seed_err_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic [LFSR_W-1:0]  data_d;
  logic               valid_d, gnt0_d, gnt1_d, busy_d, seed_err_d;

  logic               lfsr_en, lfsr_ld;
  logic [LFSR_W-1:0]  lfsr_ld_val;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_nxt;

  // A zero seed would lock the LFSR, so it is remapped to the default.
  assign lfsr_ld_val = (seed_i == '0) ? LFSR_SEED_DEF : seed_i;

  lfsr4_ld u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (lfsr_en),
    .ld     (lfsr_ld),
    .ld_val (lfsr_ld_val),
    .q      (lfsr_q),
    .next   (lfsr_nxt)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    data_d       = data_o;
    valid_d      = 1'b0;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    busy_d       = busy_o;
    seed_err_d   = 1'b0;
    lfsr_en      = 1'b0;
    lfsr_ld      = 1'b0;
    case (state_q)
      IDLE: begin
        if (seed_we_i) begin
          lfsr_ld = 1'b1;
        end else if (!valid_o && (req0_i || req1_i)) begin
          // Masking on valid_o keeps the just-granted requester from winning again.
          owner_d = (req0_i && req1_i) ? ~last_owner_q : req1_i;
          cnt_d   = CNT_W'(STEPS - 1);
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        lfsr_en    = 1'b1;
        seed_err_d = seed_we_i;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          data_d       = lfsr_nxt;
          valid_d      = 1'b1;
          gnt0_d       = ~owner_q;
          gnt1_d       = owner_q;
          last_owner_d = owner_q;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      data_o       <= '0;
      valid_o      <= 1'b0;
      gnt0_o       <= 1'b0;
      gnt1_o       <= 1'b0;
      busy_o       <= 1'b0;
      seed_err_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      data_o       <= data_d;
      valid_o      <= valid_d;
      gnt0_o       <= gnt0_d;
      gnt1_o       <= gnt1_d;
      busy_o       <= busy_d;
      seed_err_o   <= seed_err_d;
    end
  end

endmodule

// File: tb/tb_lfsr_rr_ctrl.sv
// Directed bench for lfsr_rr_ctrl with hand-computed LFSR words.
// Sequence from 0001: 1000 1100 1110 1111 0111 1011 0101 1010 1101 0110 0011 1001 0100 0010 0001.
module tb_lfsr_rr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       seed_we;
  logic [3:0] seed;
  logic       req0, req1;
  logic       gnt0, gnt1, valid, busy, seed_err;
  logic [3:0] data;

  int checks = 0;
  int errors = 0;

  lfsr_rr_ctrl #(.STEPS(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_we_i  (seed_we),
    .seed_i     (seed),
    .req0_i     (req0),
    .req1_i     (req1),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1),
    .valid_o    (valid),
    .data_o     (data),
    .busy_o     (busy),
    .seed_err_o (seed_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; seed_we = 1'b0; seed = 4'b0000; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns the 1-based negedge count at which valid was seen, or -1 on timeout.
  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; seed_we = 1'b0; seed = 4'b0000; req0 = 1'b0; req1 = 1'b0;
    #1;
    checks++;
    if ({valid, gnt0, gnt1, busy, seed_err} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {valid, gnt0, gnt1, busy, seed_err});
    end
    checks++;
    if (data !== 4'b0000) begin
      errors++;
      $display("FAIL reset_data: got %b expected 0000", data);
    end
    checks++;
    if (dut.u_lfsr.q !== 4'b0001) begin
      errors++;
      $display("FAIL reset_lfsr: got %b expected 0001", dut.u_lfsr.q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] exp_q [5] = '{4'b0001, 4'b1000, 4'b1100, 4'b1110, 4'b1111};
    bit         exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit         exp_v [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    req0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, valid, gnt0, gnt1} !== {exp_b[i], exp_v[i], exp_v[i], 1'b0}) begin
        errors++;
        $display("FAIL single_flags[%0d]: busy/valid/gnt0/gnt1 got %b expected %b", i,
                 {busy, valid, gnt0, gnt1}, {exp_b[i], exp_v[i], exp_v[i], 1'b0});
      end
      checks++;
      if (dut.u_lfsr.q !== exp_q[i]) begin
        errors++;
        $display("FAIL single_lfsr[%0d]: got %b expected %b", i, dut.u_lfsr.q, exp_q[i]);
      end
    end
    checks++;
    if (data !== 4'b1111) begin
      errors++;
      $display("FAIL single_data: got %b expected 1111", data);
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid, gnt0, data} !== {1'b0, 1'b0, 4'b1111}) begin
      errors++;
      $display("FAIL single_hold: valid/gnt0/data got %b expected 001111", {valid, gnt0, data});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_d [4] = '{4'b1111, 4'b1010, 4'b1001, 4'b1000};
    bit         exp_g0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int pulses = 0;
    int last = 0;
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 1; i <= 60 && pulses < 4; i++) begin
      @(negedge clk);
      if (valid) begin
        checks++;
        if ({gnt0, gnt1, data} !== {exp_g0[pulses], ~exp_g0[pulses], exp_d[pulses]}) begin
          errors++;
          $display("FAIL rr_word[%0d]: gnt0/gnt1/data got %b expected %b", pulses,
                   {gnt0, gnt1, data}, {exp_g0[pulses], ~exp_g0[pulses], exp_d[pulses]});
        end
        checks++;
        if ((i - last) !== ((pulses == 0) ? 5 : 6)) begin
          errors++;
          $display("FAIL rr_gap[%0d]: got %0d cycles expected %0d", pulses, i - last,
                   (pulses == 0) ? 5 : 6);
        end
        last = i;
        pulses++;
      end
    end
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("FAIL rr_count: got %0d pulses expected 4", pulses);
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_seed_zero();
    int cyc;
    do_reset();
    seed_we = 1'b1;
    seed = 4'b0110;
    @(negedge clk);
    seed = 4'b0000;
    @(negedge clk);
    seed_we = 1'b0;
    checks++;
    if (dut.u_lfsr.q !== 4'b0001) begin
      errors++;
      $display("FAIL seed_zero_remap: got %b expected 0001", dut.u_lfsr.q);
    end
    req1 = 1'b1;
    wait_valid(cyc);
    req1 = 1'b0;
    checks++;
    if ({cyc == 5, gnt0, gnt1, data} !== {1'b1, 1'b0, 1'b1, 4'b1111}) begin
      errors++;
      $display("FAIL seed_zero_word: latency %0d gnt0/gnt1/data %b expected latency 5 011111",
               cyc, {gnt0, gnt1, data});
    end
  endtask

  task automatic test_seed_value();
    int cyc;
    do_reset();
    seed_we = 1'b1;
    seed = 4'b0110;
    @(negedge clk);
    seed_we = 1'b0;
    checks++;
    if (dut.u_lfsr.q !== 4'b0110) begin
      errors++;
      $display("FAIL seed_value_load: got %b expected 0110", dut.u_lfsr.q);
    end
    req0 = 1'b1;
    wait_valid(cyc);
    req0 = 1'b0;
    checks++;
    if ({cyc == 5, gnt0, gnt1, data} !== {1'b1, 1'b1, 1'b0, 4'b0010}) begin
      errors++;
      $display("FAIL seed_value_word: latency %0d gnt0/gnt1/data %b expected latency 5 100010",
               cyc, {gnt0, gnt1, data});
    end
  endtask

  task automatic test_seed_with_req();
    int cyc;
    do_reset();
    seed_we = 1'b1;
    seed = 4'b0110;
    req0 = 1'b1;
    @(negedge clk);
    seed_we = 1'b0;
    checks++;
    if ({busy, dut.u_lfsr.q} !== {1'b0, 4'b0110}) begin
      errors++;
      $display("FAIL seed_req_same: busy/lfsr got %b expected 00110", {busy, dut.u_lfsr.q});
    end
    wait_valid(cyc);
    req0 = 1'b0;
    checks++;
    if ({cyc == 5, gnt0, data} !== {1'b1, 1'b1, 4'b0010}) begin
      errors++;
      $display("FAIL seed_req_word: latency %0d gnt0/data %b expected latency 5 10010",
               cyc, {gnt0, data});
    end
  endtask

  task automatic test_seed_in_run();
    int cyc;
    do_reset();
    req0 = 1'b1;
    @(negedge clk);
    seed_we = 1'b1;
    seed = 4'b0110;
    @(negedge clk);
    seed_we = 1'b0;
    checks++;
    if (seed_err !== 1'b1) begin
      errors++;
      $display("FAIL run_seed_err_set: got %b expected 1", seed_err);
    end
    @(negedge clk);
    checks++;
    if (seed_err !== 1'b0) begin
      errors++;
      $display("FAIL run_seed_err_clr: got %b expected 0", seed_err);
    end
    wait_valid(cyc);
    req0 = 1'b0;
    checks++;
    if ({cyc == 2, gnt0, data} !== {1'b1, 1'b1, 4'b1111}) begin
      errors++;
      $display("FAIL run_seed_word: latency %0d gnt0/data %b expected latency 2 11111",
               cyc, {gnt0, data});
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    do_reset();
    req0 = 1'b1;
    wait_valid(cyc);
    req0 = 1'b0;
    checks++;
    if ({cyc == 5, data} !== {1'b1, 4'b1111}) begin
      errors++;
      $display("FAIL midrst_first: latency %0d data %b expected latency 5 data 1111", cyc, data);
    end
    @(negedge clk);
    req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, gnt0, gnt1, busy, seed_err, data, dut.u_lfsr.q} !== {5'b00000, 4'b0000, 4'b0001}) begin
      errors++;
      $display("FAIL midrst_async: flags/data/lfsr got %b expected 0000000000001",
               {valid, gnt0, gnt1, busy, seed_err, data, dut.u_lfsr.q});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(cyc);
    req0 = 1'b0;
    checks++;
    if ({cyc == 5, gnt0, data} !== {1'b1, 1'b1, 4'b1111}) begin
      errors++;
      $display("FAIL midrst_after: latency %0d gnt0/data %b expected latency 5 11111",
               cyc, {gnt0, data});
    end
  endtask

  initial begin
    rst_n = 1'b0; seed_we = 1'b0; seed = 4'b0000; req0 = 1'b0; req1 = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_seed_zero();
    test_seed_value();
    test_seed_with_req();
    test_seed_in_run();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
